// File: rtl/usb_hid_report_if.sv
// -----------------------------------------------------------------------------
// usb_hid_report_if
// Interrupt-IN endpoint handshake between the HID report source and the USB
// packet engine.
//   master : report source (drives report bytes, data toggle, constant flags)
//   slave  : packet engine (drives stall, host ACK and packet error)
// Signals:
//   IN_Sequence    DATA0/DATA1 toggle for the endpoint
//   IN_Data        current report byte
//   IN_Ready       IN_Data valid
//   IN_ZeroLength  zero-length packet request (unused, tied low)
//   IN_WaitRequest engine stall; byte not accepted while high
//   IN_Ack         host ACK of the completed packet, single-cycle pulse
//   IN_Isochronous isochronous endpoint flag (unused, tied low)
//   Error          packet engine error; aborts the current packet
// -----------------------------------------------------------------------------
interface usb_hid_report_if;
  logic       IN_Sequence;
  logic [7:0] IN_Data;
  logic       IN_Ready;
  logic       IN_ZeroLength;
  logic       IN_WaitRequest;
  logic       IN_Ack;
  logic       IN_Isochronous;
  logic       Error;

  modport master (
    output IN_Sequence, IN_Data, IN_Ready, IN_ZeroLength, IN_Isochronous,
    input  IN_WaitRequest, IN_Ack, Error
  );

  modport slave (
    input  IN_Sequence, IN_Data, IN_Ready, IN_ZeroLength, IN_Isochronous,
    output IN_WaitRequest, IN_Ack, Error
  );
endinterface

// File: rtl/usb_hid_report.sv
// -----------------------------------------------------------------------------
// usb_hid_report
// HID interrupt-IN report source. Samples an N_BUTTONS-wide status vector,
// and whenever it changes (or the idle re-send interval expires) serialises
// an optional report-ID byte followed by the status bytes (LSB first, unused
// MSBs zero) onto the endpoint byte stream. Packet errors restart the report
// from byte 0 up to MAX_RETRIES times, after which the report is dropped.
// Ports:
//   Clk      system clock
//   Reset    synchronous, active-high reset
//   in_if    endpoint handshake (master side)
//   Status   asynchronous button/status vector, bit0 first
//   Busy     high whenever a report is in flight (state other than IDLE)
//   Dropped  one-cycle pulse when a report is abandoned
// -----------------------------------------------------------------------------
module usb_hid_report #(
  parameter int         N_BUTTONS   = 6,
  parameter logic [7:0] REPORT_ID   = 8'd1,
  parameter int         IDLE_CYCLES = 0,
  parameter int         MAX_RETRIES = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  usb_hid_report_if.master     in_if,
  input  logic [N_BUTTONS-1:0] Status,
  output logic                 Busy,
  output logic                 Dropped
);

  localparam int PB     = (N_BUTTONS + 7) / 8;
  localparam int HAS_ID = (REPORT_ID != 8'd0) ? 1 : 0;
  localparam int NB     = PB + HAS_ID;
  localparam int IW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW     = $clog2(MAX_RETRIES + 2);
  localparam int TW     = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NB - 1);
  localparam logic [TW-1:0] TIMER_MAX = (IDLE_CYCLES > 0) ? TW'(IDLE_CYCLES - 1) : '0;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  // Byte idx of the report built from snap: optional ID byte, then payload.
  function automatic logic [7:0] report_byte(input logic [N_BUTTONS-1:0] snap,
                                             input logic [IW-1:0]        idx);
    logic [PB*8-1:0] payload;
    int              pos;
    payload                 = '0;
    payload[N_BUTTONS-1:0]  = snap;
    pos                     = int'(idx) - HAS_ID;
    report_byte             = 8'h00;
    if (pos < 0) begin
      report_byte = REPORT_ID;
    end else begin
      for (int i = 0; i < PB; i++) begin
        if (pos == i) begin
          report_byte = payload[i*8 +: 8];
        end else begin
          report_byte = report_byte;
        end
      end
    end
  endfunction

  state_t               state_r, state_nxt_s;
  logic [N_BUTTONS-1:0] sync1_r, sync2_r;
  logic [N_BUTTONS-1:0] snap_r, snap_nxt_s;
  logic [N_BUTTONS-1:0] last_r, last_nxt_s;
  logic [IW-1:0]        idx_r, idx_nxt_s;
  logic [RW-1:0]        retry_r, retry_nxt_s, retry_inc_s;
  logic [TW-1:0]        timer_r, timer_nxt_s;
  logic [7:0]           data_r, data_nxt_s;
  logic                 ready_r, ready_nxt_s;
  logic                 seq_r, seq_nxt_s;
  logic                 busy_r;
  logic                 dropped_r, dropped_nxt_s;
  logic                 accept_s, trigger_s, give_up_s;

  // Two-flop synchroniser for the asynchronous status vector.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= Status;
      sync2_r <= sync1_r;
    end
  end

  // Next-state and next-output logic for the report FSM.
  always_comb begin
    state_nxt_s   = state_r;
    snap_nxt_s    = snap_r;
    last_nxt_s    = last_r;
    idx_nxt_s     = idx_r;
    retry_nxt_s   = retry_r;
    data_nxt_s    = data_r;
    ready_nxt_s   = ready_r;
    seq_nxt_s     = seq_r;
    dropped_nxt_s = 1'b0;

    accept_s    = ready_r & ~in_if.IN_WaitRequest & ~in_if.Error;
    retry_inc_s = retry_r + 1'b1;
    give_up_s   = (MAX_RETRIES != 0) && (retry_inc_s > RETRY_MAX);
    trigger_s   = (sync2_r != last_r) || ((IDLE_CYCLES > 0) && (timer_r == TIMER_MAX));

    // Idle timer free-runs and saturates; a send start clears it below.
    if (IDLE_CYCLES == 0) begin
      timer_nxt_s = '0;
    end else if (timer_r == TIMER_MAX) begin
      timer_nxt_s = timer_r;
    end else begin
      timer_nxt_s = timer_r + 1'b1;
    end

    case (state_r)
      ST_IDLE: begin
        if (trigger_s) begin
          snap_nxt_s  = sync2_r;
          last_nxt_s  = sync2_r;
          idx_nxt_s   = '0;
          retry_nxt_s = '0;
          timer_nxt_s = '0;
          data_nxt_s  = report_byte(sync2_r, '0);
          ready_nxt_s = 1'b1;
          state_nxt_s = ST_SEND;
        end else begin
          ready_nxt_s = 1'b0;
        end
      end

      ST_SEND, ST_WAIT_ACK: begin
        if (in_if.Error) begin
          // Error beats both byte accept and host ACK.
          retry_nxt_s = retry_inc_s;
          if (give_up_s) begin
            ready_nxt_s   = 1'b0;
            dropped_nxt_s = 1'b1;
            state_nxt_s   = ST_IDLE;
          end else begin
            idx_nxt_s   = '0;
            data_nxt_s  = report_byte(snap_r, '0);
            ready_nxt_s = 1'b1;
            state_nxt_s = ST_SEND;
          end
        end else if (state_r == ST_SEND) begin
          if (accept_s && (idx_r == LAST_IDX)) begin
            ready_nxt_s = 1'b0;
            state_nxt_s = ST_WAIT_ACK;
          end else if (accept_s) begin
            idx_nxt_s  = idx_r + 1'b1;
            data_nxt_s = report_byte(snap_r, idx_r + 1'b1);
          end else begin
            data_nxt_s = data_r;
          end
        end else if (in_if.IN_Ack) begin
          seq_nxt_s   = ~seq_r;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end

      default: begin
        ready_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered endpoint outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      snap_r    <= '0;
      last_r    <= '0;
      idx_r     <= '0;
      retry_r   <= '0;
      timer_r   <= '0;
      data_r    <= 8'h00;
      ready_r   <= 1'b0;
      seq_r     <= 1'b0;
      busy_r    <= 1'b0;
      dropped_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      snap_r    <= snap_nxt_s;
      last_r    <= last_nxt_s;
      idx_r     <= idx_nxt_s;
      retry_r   <= retry_nxt_s;
      timer_r   <= timer_nxt_s;
      data_r    <= data_nxt_s;
      ready_r   <= ready_nxt_s;
      seq_r     <= seq_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      dropped_r <= dropped_nxt_s;
    end
  end

  assign in_if.IN_Data        = data_r;
  assign in_if.IN_Ready       = ready_r;
  assign in_if.IN_Sequence    = seq_r;
  assign in_if.IN_ZeroLength  = 1'b0;
  assign in_if.IN_Isochronous = 1'b0;
  assign Busy                 = busy_r;
  assign Dropped              = dropped_r;

endmodule

// File: tb/tb_usb_hid_report.sv
// -----------------------------------------------------------------------------
// tb_usb_hid_report
// Two report sources with different shapes: unit 0 has a report ID, a
// 12-bit status and change-only reporting; unit 1 has no ID, a 10-bit status
// and a 100-cycle idle re-send. Randomised status values and stalls are
// checked against report contents computed from the byte layout rules.
// -----------------------------------------------------------------------------
module tb_usb_hid_report;
  localparam int         N0    = 12;
  localparam logic [7:0] ID0   = 8'h2A;
  localparam int         MAX0  = 3;
  localparam int         N1    = 10;
  localparam logic [7:0] ID1   = 8'h00;
  localparam int         IDLE1 = 100;
  localparam int         MAX1  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst [2];
  logic [11:0] stv [2];
  logic        wr  [2];
  logic        ack [2];
  logic        err [2];
  logic        rdy [2];
  logic        seq [2];
  logic        zl  [2];
  logic        iso [2];
  logic        busy[2];
  logic        drp [2];
  logic [7:0]  dat [2];
  logic        exp_seq[2];
  int          t_start[2];

  int n_checks = 0;
  int n_err    = 0;

  usb_hid_report_if if0 ();
  usb_hid_report_if if1 ();

  assign if0.IN_WaitRequest = wr[0];
  assign if0.IN_Ack         = ack[0];
  assign if0.Error          = err[0];
  assign if1.IN_WaitRequest = wr[1];
  assign if1.IN_Ack         = ack[1];
  assign if1.Error          = err[1];
  assign rdy[0] = if0.IN_Ready;
  assign seq[0] = if0.IN_Sequence;
  assign dat[0] = if0.IN_Data;
  assign zl[0]  = if0.IN_ZeroLength;
  assign iso[0] = if0.IN_Isochronous;
  assign rdy[1] = if1.IN_Ready;
  assign seq[1] = if1.IN_Sequence;
  assign dat[1] = if1.IN_Data;
  assign zl[1]  = if1.IN_ZeroLength;
  assign iso[1] = if1.IN_Isochronous;

  usb_hid_report #(.N_BUTTONS(N0), .REPORT_ID(ID0), .IDLE_CYCLES(0), .MAX_RETRIES(MAX0)) u_dut0 (
    .Clk(clk), .Reset(rst[0]), .in_if(if0), .Status(stv[0]), .Busy(busy[0]), .Dropped(drp[0])
  );

  usb_hid_report #(.N_BUTTONS(N1), .REPORT_ID(ID1), .IDLE_CYCLES(IDLE1), .MAX_RETRIES(MAX1)) u_dut1 (
    .Clk(clk), .Reset(rst[1]), .in_if(if1), .Status(stv[1][N1-1:0]), .Busy(busy[1]), .Dropped(drp[1])
  );

  // ---------------- reference model ----------------
  function automatic int nbits(int d);
    return (d == 0) ? N0 : N1;
  endfunction

  function automatic logic [7:0] rid(int d);
    return (d == 0) ? ID0 : ID1;
  endfunction

  function automatic int nbytes(int d);
    return (nbits(d) + 7) / 8 + ((rid(d) != 8'h00) ? 1 : 0);
  endfunction

  // Report byte i for status s: [ID] then status bytes LSB first, zero padded.
  function automatic logic [7:0] exp_byte(int d, logic [11:0] s, int i);
    logic [15:0] pl;
    int          k;
    pl = 16'h0000;
    for (int b = 0; b < nbits(d); b++) pl[b] = s[b];
    k = i;
    if (rid(d) != 8'h00) begin
      if (i == 0) return rid(d);
      k = i - 1;
    end
    return pl[k*8 +: 8];
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d, input logic [11:0] s);
    stv[d] = s; wr[d] = 1'b0; ack[d] = 1'b0; err[d] = 1'b0;
    rst[d] = 1'b1;
    step(); step();
    check("rst_ready", rdy[d], 1'b0);
    check("rst_data", dat[d], 8'h00);
    check("rst_seq", seq[d], 1'b0);
    check("rst_busy", busy[d], 1'b0);
    check("rst_dropped", drp[d], 1'b0);
    check("zero_length", zl[d], 1'b0);
    check("isochronous", iso[d], 1'b0);
    rst[d] = 1'b0;
    exp_seq[d] = 1'b0;
  endtask

  // Edges until IN_Ready is seen, bounded; records the send-start cycle.
  task automatic wait_ready(input int d, input int bound, output int lat);
    lat = 0;
    while (!rdy[d] && lat < bound) begin
      step();
      lat++;
    end
    check("ready_seen", rdy[d], 1'b1);
    t_start[d] = cyc;
  endtask

  // Accept a whole report with random stalls, checking every byte.
  task automatic collect(input int d, input logic [11:0] s);
    int k;
    for (int i = 0; i < nbytes(d); i++) begin
      check("byte_valid", rdy[d], 1'b1);
      check("byte_value", dat[d], exp_byte(d, s, i));
      k = $urandom_range(0, 3);
      wr[d] = 1'b1;
      for (int j = 0; j < k; j++) begin
        step();
        check("stall_hold", dat[d], exp_byte(d, s, i));
      end
      wr[d] = 1'b0;
      step();
    end
    check("done_ready", rdy[d], 1'b0);
    check("done_busy", busy[d], 1'b1);
  endtask

  task automatic ack_pkt(input int d);
    ack[d] = 1'b1;
    step();
    ack[d] = 1'b0;
    exp_seq[d] = ~exp_seq[d];
    check("ack_seq", seq[d], exp_seq[d]);
    check("ack_busy", busy[d], 1'b0);
    check("ack_ready", rdy[d], 1'b0);
  endtask

  function automatic logic [11:0] new_status(int d, logic [11:0] old);
    logic [11:0] v;
    int          m;
    m = (1 << nbits(d)) - 1;
    v = old;
    while (v == old) v = 12'($urandom_range(1, m));
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] s, s2;
    int          lat, ne;
    logic        seen;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; stv[d] = 12'h000; wr[d] = 1'b0; ack[d] = 1'b0; err[d] = 1'b0;
      exp_seq[d] = 1'b0; t_start[d] = 0;
    end

    // Unit 0: reset, latency and first report.
    s = new_status(0, 12'h000);
    do_reset(0, s);
    wait_ready(0, 10, lat);
    check("latency_reset", lat, 3);
    collect(0, s);
    ack_pkt(0);

    // Unit 0: random reports with retries below the limit.
    for (int it = 0; it < 6; it++) begin
      s = new_status(0, s);
      stv[0] = s;
      wait_ready(0, 10, lat);
      check("latency_change", lat, 3);
      ne = $urandom_range(0, MAX0);
      for (int e = 0; e < ne; e++) begin
        if ($urandom_range(0, 1) == 1) begin
          wr[0] = 1'b0;
          step();
          check("second_byte", dat[0], exp_byte(0, s, 1));
          err[0] = 1'b1;
          step();
          err[0] = 1'b0;
        end else begin
          collect(0, s);
          err[0] = 1'b1; ack[0] = 1'b1;
          step();
          err[0] = 1'b0; ack[0] = 1'b0;
          check("err_wins_seq", seq[0], exp_seq[0]);
        end
        check("retry_ready", rdy[0], 1'b1);
        check("retry_byte0", dat[0], exp_byte(0, s, 0));
        check("retry_no_drop", drp[0], 1'b0);
      end
      collect(0, s);
      ack_pkt(0);
    end

    // Unit 0: MAX0+1 failed attempts drop the report.
    s = new_status(0, s);
    stv[0] = s;
    wait_ready(0, 10, lat);
    for (int a = 0; a <= MAX0; a++) begin
      collect(0, s);
      err[0] = 1'b1;
      step();
      err[0] = 1'b0;
      if (a < MAX0) begin
        check("attempt_restart", rdy[0], 1'b1);
        check("attempt_no_drop", drp[0], 1'b0);
      end else begin
        check("drop_pulse", drp[0], 1'b1);
        check("drop_ready", rdy[0], 1'b0);
        check("drop_busy", busy[0], 1'b0);
        check("drop_seq", seq[0], exp_seq[0]);
      end
    end
    step();
    check("drop_one_cycle", drp[0], 1'b0);
    seen = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (rdy[0]) seen = 1'b1;
    end
    check("no_resend_after_drop", seen, 1'b0);

    // Unit 0: change during transfer is sent right after the ACK.
    s = new_status(0, s);
    stv[0] = s;
    wait_ready(0, 10, lat);
    s2 = new_status(0, s);
    stv[0] = s2;
    collect(0, s);
    step(); step(); step();
    ack_pkt(0);
    wait_ready(0, 5, lat);
    check("latency_after_ack", lat, 1);
    collect(0, s2);
    ack_pkt(0);

    // Unit 0: reset while sending byte 1.
    s = new_status(0, s2);
    stv[0] = s;
    wait_ready(0, 10, lat);
    wr[0] = 1'b0;
    step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    exp_seq[0] = 1'b0;
    check("midrst_ready", rdy[0], 1'b0);
    check("midrst_seq", seq[0], 1'b0);
    check("midrst_busy", busy[0], 1'b0);
    wait_ready(0, 10, lat);
    check("latency_after_reset", lat, 3);
    collect(0, s);
    ack_pkt(0);

    // Unit 1: no report ID, idle re-send every IDLE1 cycles.
    s = new_status(1, 12'h000);
    do_reset(1, s);
    wait_ready(1, 10, lat);
    check("u1_latency_reset", lat, 3);
    collect(1, s);
    ack_pkt(1);
    for (int k = 0; k < 3; k++) begin
      ne = t_start[1];
      wait_ready(1, IDLE1 + 20, lat);
      check("idle_period", t_start[1] - ne, IDLE1);
      collect(1, s);
      ack_pkt(1);
    end
    ne = t_start[1];
    wait_ready(1, IDLE1 + 20, lat);
    check("idle_period", t_start[1] - ne, IDLE1);
    s2 = new_status(1, s);
    stv[1] = s2;
    collect(1, s);
    step(); step(); step();
    ack_pkt(1);
    wait_ready(1, 5, lat);
    check("u1_latency_after_ack", lat, 1);
    collect(1, s2);
    ack_pkt(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/usb_hid_report.md
Name: usb_hid_report

Overview:
- Parametrised HID interrupt-IN report source; successor to the fixed 6-button media-key reporter.
- Samples an N-bit button/status vector and serialises a report onto one bulk/interrupt IN endpoint byte stream, ahead of the USB packet engine.
- Adds configurable report width and optional report ID.
- Adds periodic idle-rate re-send, bounded retry on Error, and a drop indication.

Parameters:
N_BUTTONS, 6, width of Status; report payload = ceil(N_BUTTONS/8) bytes, LSB first, unused MSBs zero
REPORT_ID, 1, 8-bit report ID prefixed as first byte; 0 = no ID byte
IDLE_CYCLES, 0, Clk cycles between unchanged re-sends, measured from last send start; 0 = disabled (send on change only)
MAX_RETRIES, 3, Error-triggered restarts allowed per report before it is dropped; 0 = unlimited

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Error  in  1  packet engine error (CRC/timeout/bus reset); aborts current packet
IN_Sequence  out  1  DATA0/DATA1 toggle for the endpoint
IN_Data  out  8  current report byte
IN_Ready  out  1  IN_Data valid; high from first byte until last byte accepted
IN_ZeroLength  out  1  constant 0
IN_WaitRequest  in  1  engine stall; byte not accepted while high
IN_Ack  in  1  host ACK of the completed packet, single-cycle pulse
IN_Isochronous  out  1  constant 0
Status  in  N_BUTTONS  asynchronous button/status vector, bit0 first
Busy  out  1  high in any state other than IDLE
Dropped  out  1  one-cycle pulse when a report is abandoned after MAX_RETRIES

Behaviour:
- Reset: IN_Ready=0, IN_Data=0, IN_Sequence=0, Busy=0, Dropped=0, state=IDLE, retry count=0, idle timer=0, last-sent snapshot=0.
- Status passes a 2-flop synchroniser; compare and snapshot use the second stage only.
- Byte count NB = ceil(N_BUTTONS/8) + (REPORT_ID!=0).
- Byte accept condition: IN_Ready & ~IN_WaitRequest & ~Error on a rising edge.
- IDLE:
  - Trigger on synced != last-sent, or (IDLE_CYCLES>0 and idle timer == IDLE_CYCLES-1).
  - On trigger: latch snapshot = synced, last-sent = synced, clear byte index, retry=0, reset idle timer.
  - In the same edge assert IN_Ready with byte 0 on IN_Data; enter SEND.
  - Latency: a Status change is stable before edge 1; IN_Ready is high after edge 3.
- SEND:
  - On each accept: advance index and present the next byte on the following edge.
  - Accept of byte NB-1: deassert IN_Ready; enter WAIT_ACK.
  - IN_Data must not change while IN_Ready is high and the byte has not been accepted.
- WAIT_ACK:
  - IN_Ack: toggle IN_Sequence; go to IDLE.
  - IN_Ack and Error in the same cycle: Error wins.
- Error in SEND or WAIT_ACK:
  - retry+1; if MAX_RETRIES!=0 and the new retry count > MAX_RETRIES, deassert IN_Ready, pulse Dropped, return to IDLE. IN_Sequence is not toggled; last-sent keeps the dropped value, so there is no immediate resend.
  - Otherwise restart from byte 0 of the same snapshot, with IN_Ready high on the next edge.
- Status changes during SEND/WAIT_ACK do not alter the in-flight snapshot. They are detected in IDLE after completion, so only the newest value is sent (no queue).
- Idle timer: free-runs and saturates at IDLE_CYCLES-1; cleared at each send start; ignored if IDLE_CYCLES=0.
- Reset mid-transfer: takes effect at the next edge; IN_Ready drops, IN_Sequence returns to 0, state returns to IDLE.

Test Plan:
- N_BUTTONS=6, REPORT_ID=1, no stall: Status 0->6'b000101 -> IN_Ready high after 3rd edge; bytes 0x01,0x05 accepted on consecutive edges; IN_Ready low; IN_Ack toggles IN_Sequence 0->1; Busy low.
- N_BUTTONS=12, REPORT_ID=0: Status=12'hA5C with IN_WaitRequest high 4 cycles on byte 0 -> IN_Data held at 0x5C through the stall, then 0x0A; exactly 2 bytes.
- Error in WAIT_ACK once, MAX_RETRIES=3 -> full resend 0x01,0x05; after Ack, IN_Sequence toggles once only.
- Error 4 times, MAX_RETRIES=3 -> 4 attempts total, Dropped pulses 1 cycle, IN_Sequence unchanged, no further send while Status is steady.
- IDLE_CYCLES=100, Status steady 0x03 -> report re-sent every 100 cycles from each send start; a change to 0x07 mid-transfer is sent immediately after the Ack.
- Reset asserted during SEND byte 1 -> next edge IN_Ready=0, IN_Sequence=0, Busy=0; with last-sent reset to 0, nonzero Status is re-reported 3 cycles after Reset deasserts.
